// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // ID/EX control vector (EX/M/WB bits) and the value a bubble forces into it
    localparam int unsigned          CTRL_W      = 8;
    localparam logic [CTRL_W-1:0]    CTRL_BUBBLE = '0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } pipe_ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs, data-memory status, pipeline enables.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             use_rs_i;
    logic             use_rt_i;
    logic [4:0]       idex_rt_i;
    logic             idex_memread_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ifid_rs_i, ifid_rt_i, use_rs_i, use_rt_i, idex_rt_i, idex_memread_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o,
               err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ifid_rs_i, ifid_rt_i, use_rs_i, use_rt_i, idex_rt_i, idex_memread_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o,
               err_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
module hazard_ctrl_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (inc && (value != MAX)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch/jump flushes,
// data-memory freeze with timeout, and stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_stall;
    logic              load_use;
    logic              flush_req;
    pipe_ctl_t         ctl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    assign mem_stall = bus.dmem_req_i & ~bus.dmem_ready_i;
    assign flush_req = bus.branch_taken_i | bus.jump_i;
    assign load_use  = bus.idex_memread_i && (bus.idex_rt_i != REG_ZERO) &&
                       ((bus.use_rs_i && (bus.ifid_rs_i == bus.idex_rt_i)) ||
                        (bus.use_rt_i && (bus.ifid_rt_i == bus.idex_rt_i)));

    // Next state plus pipeline enables, priority ERR > mem stall > load-use > flush
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctl     = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                    idex_bubble: 1'b0, pipe_freeze: 1'b0};

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_stall) begin
                    if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            end
            ST_ERR: ;
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase

        if (rst_i) begin
            ctl.pc_write    = 1'b0;
            ctl.ifid_write  = 1'b0;
            ctl.idex_bubble = 1'b1;
        end else if (state_q == ST_ERR) begin
            ctl.pc_write    = 1'b0;
            ctl.ifid_write  = 1'b0;
            ctl.idex_bubble = 1'b1;
            ctl.pipe_freeze = 1'b1;
        end else if (mem_stall) begin
            // ID instruction is held in place, not killed
            ctl.pc_write    = 1'b0;
            ctl.ifid_write  = 1'b0;
            ctl.pipe_freeze = 1'b1;
        end else if (load_use) begin
            // Branch operands are not ready yet, so a flush waits for the replay
            ctl.pc_write    = 1'b0;
            ctl.ifid_write  = 1'b0;
            ctl.idex_bubble = 1'b1;
        end else if (flush_req) begin
            ctl.ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    hazard_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .clear (rst_i),
        .inc   (~ctl.pc_write),
        .value (stall_cnt)
    );

    hazard_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .clear (rst_i),
        .inc   (ctl.ifid_flush),
        .value (flush_cnt)
    );

    assign bus.pc_write_o    = ctl.pc_write;
    assign bus.ifid_write_o  = ctl.ifid_write;
    assign bus.ifid_flush_o  = ctl.ifid_flush;
    assign bus.idex_bubble_o = ctl.idex_bubble;
    assign bus.pipe_freeze_o = ctl.pipe_freeze;
    assign bus.err_o         = (state_q == ST_ERR);
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (hif)
    );

    int checks = 0;
    int errors = 0;

    // Model state: consecutive memory-wait cycles, error flag, event counts
    bit m_err   = 1'b0;
    int m_wait  = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_in();
        hif.ifid_rs_i      = 5'd0;
        hif.ifid_rt_i      = 5'd0;
        hif.use_rs_i       = 1'b0;
        hif.use_rt_i       = 1'b0;
        hif.idex_rt_i      = 5'd0;
        hif.idex_memread_i = 1'b0;
        hif.branch_taken_i = 1'b0;
        hif.jump_i         = 1'b0;
        hif.dmem_req_i     = 1'b0;
        hif.dmem_ready_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        hif.idex_rt_i      = 5'd2;
        hif.idex_memread_i = 1'b1;
        hif.ifid_rs_i      = 5'd2;
        hif.use_rs_i       = 1'b1;
    endtask

    // Model: expected outputs straight from the priority rules, checked every cycle
    always @(negedge clk) begin : model_chk
        logic ms, lu;
        logic e_pc, e_ifw, e_fl, e_bub, e_frz;
        logic [CTRL_W-1:0] idex_ctrl;
        ms = hif.dmem_req_i & ~hif.dmem_ready_i;
        lu = hif.idex_memread_i && (hif.idex_rt_i != 5'd0) &&
             ((hif.use_rs_i && (hif.ifid_rs_i == hif.idex_rt_i)) ||
              (hif.use_rt_i && (hif.ifid_rt_i == hif.idex_rt_i)));
        if (rst)        {e_pc, e_ifw, e_fl, e_bub, e_frz} = 5'b00010;
        else if (m_err) {e_pc, e_ifw, e_fl, e_bub, e_frz} = 5'b00011;
        else if (ms)    {e_pc, e_ifw, e_fl, e_bub, e_frz} = 5'b00001;
        else if (lu)    {e_pc, e_ifw, e_fl, e_bub, e_frz} = 5'b00010;
        else            {e_pc, e_ifw, e_fl, e_bub, e_frz} =
                            {2'b11, hif.branch_taken_i | hif.jump_i, 2'b00};

        chk("m_pc_write",    32'(hif.pc_write_o),    32'(e_pc));
        chk("m_ifid_write",  32'(hif.ifid_write_o),  32'(e_ifw));
        chk("m_ifid_flush",  32'(hif.ifid_flush_o),  32'(e_fl));
        chk("m_idex_bubble", 32'(hif.idex_bubble_o), 32'(e_bub));
        chk("m_pipe_freeze", 32'(hif.pipe_freeze_o), 32'(e_frz));
        chk("m_err",         32'(hif.err_o),         32'(m_err));
        chk("m_stall_cnt",   32'(hif.stall_cnt_o),   32'(m_stall));
        chk("m_flush_cnt",   32'(hif.flush_cnt_o),   32'(m_flush));
        idex_ctrl = hif.idex_bubble_o ? CTRL_BUBBLE : 8'hA5;
        if (e_bub) chk("m_idex_ctrl", 32'(idex_ctrl), 32'h0);

        if (rst) begin
            m_err   = 1'b0;
            m_wait  = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e_pc && m_stall < CNT_MAX) m_stall++;
            if (e_fl && m_flush < CNT_MAX)  m_flush++;
            if (!m_err) begin
                if (ms) begin
                    m_wait++;
                    if (m_wait == TIMEOUT) m_err = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    end

    initial begin
        // Reset dominates a pending flush
        rst = 1'b1;
        clear_in();
        hif.branch_taken_i = 1'b1;
        #1;
        chk("rst_pc_write", 32'(hif.pc_write_o),    32'd0);
        chk("rst_bubble",   32'(hif.idex_bubble_o), 32'd1);
        chk("rst_flush",    32'(hif.ifid_flush_o),  32'd0);
        chk("rst_freeze",   32'(hif.pipe_freeze_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        clear_in();
        #1;
        chk("rst_err",       32'(hif.err_o),       32'd0);
        chk("rst_stall_cnt", 32'(hif.stall_cnt_o), 32'd0);
        chk("rst_flush_cnt", 32'(hif.flush_cnt_o), 32'd0);
        tick();

        // Load-use: one bubble, then normal flow
        reset_dut();
        set_load_use();
        #1;
        chk("lu_pc_write", 32'(hif.pc_write_o),    32'd0);
        chk("lu_bubble",   32'(hif.idex_bubble_o), 32'd1);
        tick();
        hif.idex_memread_i = 1'b0;
        #1;
        chk("lu_next_pc",     32'(hif.pc_write_o),    32'd1);
        chk("lu_next_bubble", 32'(hif.idex_bubble_o), 32'd0);
        chk("lu_stall_cnt",   32'(hif.stall_cnt_o),   32'd1);
        tick();
        clear_in();

        // No hazard through $zero or when no source is read; rt path does stall
        reset_dut();
        hif.idex_rt_i = 5'd0; hif.idex_memread_i = 1'b1;
        hif.ifid_rs_i = 5'd0; hif.use_rs_i = 1'b1;
        #1;
        chk("zero_pc_write", 32'(hif.pc_write_o), 32'd1);
        tick();
        hif.idex_rt_i = 5'd2; hif.ifid_rs_i = 5'd2; hif.ifid_rt_i = 5'd2;
        hif.use_rs_i = 1'b0; hif.jump_i = 1'b1;
        #1;
        chk("jump_pc_write", 32'(hif.pc_write_o),   32'd1);
        chk("jump_flush",    32'(hif.ifid_flush_o), 32'd1);
        tick();
        chk("nohaz_stall_cnt", 32'(hif.stall_cnt_o), 32'd0);
        chk("jump_flush_cnt",  32'(hif.flush_cnt_o), 32'd1);
        hif.jump_i = 1'b0; hif.use_rt_i = 1'b1;
        #1;
        chk("rt_lu_pc_write", 32'(hif.pc_write_o), 32'd0);
        tick();
        clear_in();

        // Taken branch alone flushes; with load-use it is suppressed
        reset_dut();
        hif.branch_taken_i = 1'b1;
        #1;
        chk("br_flush",    32'(hif.ifid_flush_o), 32'd1);
        chk("br_pc_write", 32'(hif.pc_write_o),   32'd1);
        tick();
        clear_in();
        #1;
        chk("br_flush_off", 32'(hif.ifid_flush_o), 32'd0);
        chk("br_flush_cnt", 32'(hif.flush_cnt_o),  32'd1);
        reset_dut();
        hif.branch_taken_i = 1'b1;
        set_load_use();
        #1;
        chk("brlu_flush",  32'(hif.ifid_flush_o),  32'd0);
        chk("brlu_bubble", 32'(hif.idex_bubble_o), 32'd1);
        tick();
        clear_in();
        chk("brlu_flush_cnt", 32'(hif.flush_cnt_o), 32'd0);
        chk("brlu_stall_cnt", 32'(hif.stall_cnt_o), 32'd1);

        // Memory wait of 3 cycles; mem stall outranks load-use and branch
        reset_dut();
        hif.dmem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_load_use();
                hif.branch_taken_i = 1'b1;
            end
            #1;
            chk("mw_freeze", 32'(hif.pipe_freeze_o), 32'd1);
            chk("mw_bubble", 32'(hif.idex_bubble_o), 32'd0);
            chk("mw_flush",  32'(hif.ifid_flush_o),  32'd0);
            tick();
            clear_in();
            hif.dmem_req_i = 1'b1;
        end
        hif.dmem_ready_i = 1'b1;
        #1;
        chk("mw_ready_freeze", 32'(hif.pipe_freeze_o), 32'd0);
        tick();
        clear_in();
        chk("mw_err",       32'(hif.err_o),       32'd0);
        chk("mw_stall_cnt", 32'(hif.stall_cnt_o), 32'd3);

        // Dropping the request clears the wait count; ready on the 4th wait cycle is in time
        for (int i = 0; i < 3; i++) begin hif.dmem_req_i = 1'b1; tick(); end
        hif.dmem_req_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin hif.dmem_req_i = 1'b1; tick(); end
        hif.dmem_ready_i = 1'b1;
        tick();
        clear_in();
        chk("drop_err", 32'(hif.err_o), 32'd0);

        // Timeout: four wait cycles, error from the fifth, released only by reset
        reset_dut();
        hif.dmem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_err", 32'(hif.err_o), 32'd0);
            tick();
        end
        hif.dmem_ready_i = 1'b1;
        #1;
        chk("to_err",      32'(hif.err_o),         32'd1);
        chk("to_pc_write", 32'(hif.pc_write_o),    32'd0);
        chk("to_freeze",   32'(hif.pipe_freeze_o), 32'd1);
        chk("to_bubble",   32'(hif.idex_bubble_o), 32'd1);
        tick();
        clear_in();
        tick();
        chk("to_err_sticky", 32'(hif.err_o),       32'd1);
        chk("to_stall_cnt",  32'(hif.stall_cnt_o), 32'd6);
        tick();
        tick();
        chk("to_stall_sat", 32'(hif.stall_cnt_o), 32'd7);
        reset_dut();
        #1;
        chk("to_rst_err",       32'(hif.err_o),       32'd0);
        chk("to_rst_stall_cnt", 32'(hif.stall_cnt_o), 32'd0);
        chk("to_rst_pc_write",  32'(hif.pc_write_o),  32'd1);
        tick();

        // Saturation at 2^CNT_W-1
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            set_load_use(); tick();
            clear_in();     tick();
        end
        chk("sat_stall_cnt", 32'(hif.stall_cnt_o), 32'd7);
        for (int i = 0; i < 10; i++) begin
            hif.branch_taken_i = 1'b1; tick();
            clear_in();                tick();
        end
        chk("sat_flush_cnt", 32'(hif.flush_cnt_o), 32'd7);

        // Mixed vectors, model-checked only
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            rst                = ($urandom_range(0, 49) == 0);
            hif.ifid_rs_i      = 5'($urandom_range(0, 3));
            hif.ifid_rt_i      = 5'($urandom_range(0, 3));
            hif.use_rs_i       = 1'($urandom_range(0, 1));
            hif.use_rt_i       = 1'($urandom_range(0, 1));
            hif.idex_rt_i      = 5'($urandom_range(0, 3));
            hif.idex_memread_i = 1'($urandom_range(0, 1));
            hif.branch_taken_i = ($urandom_range(0, 7) == 0);
            hif.jump_i         = ($urandom_range(0, 7) == 0);
            hif.dmem_req_i     = ($urandom_range(0, 2) == 0);
            hif.dmem_ready_i   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        clear_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the ID-stage control decoder.
- Decides each cycle whether PC and IF/ID advance, whether IF/ID is flushed (taken branch/jump), and whether ID/EX receives a bubble (all 8 EX/M/WB control bits zeroed).
- Freezes the whole pipeline while the data memory has not acknowledged an access, with timeout detection and stall/flush performance counters.

Parameters:
- TIMEOUT, 16, maximum consecutive data-memory wait cycles before entering error state (>=2).
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ifid_rs_i  in  5  rs field of instruction in ID
- ifid_rt_i  in  5  rt field of instruction in ID
- use_rs_i  in  1  ID instruction reads rs (R-type, addi, lw, sw, beq)
- use_rt_i  in  1  ID instruction reads rt (R-type, sw, beq)
- idex_rt_i  in  5  destination rt of instruction in EX
- idex_memread_i  in  1  MemRead control bit of instruction in EX
- branch_taken_i  in  1  branch control AND register-equal, resolved in ID
- jump_i  in  1  jump control of instruction in ID
- dmem_req_i  in  1  EX/MEM holds lw or sw
- dmem_ready_i  in  1  data memory completes access this cycle
- pc_write_o  out  1  PC register enable
- ifid_write_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  IF/ID loads a nop
- idex_bubble_o  out  1  force ID/EX control bits to 8'b0
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- err_o  out  1  sticky memory-timeout flag
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 (saturating)
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1 (saturating)

Behaviour:
- Clock clk_i, reset rst_i: one clock; reset is synchronous and active-high.
- FSM states: RUN, WAIT, ERR. Reset -> RUN, wait counter 0, stall_cnt_o=0, flush_cnt_o=0, err_o=0.
- While rst_i=1: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, pipe_freeze_o=0.
- mem_stall = dmem_req_i & ~dmem_ready_i (combinational, same cycle).
- load_use = idex_memread_i & (idex_rt_i!=0) & ((use_rs_i & ifid_rs_i==idex_rt_i) | (use_rt_i & ifid_rt_i==idex_rt_i)).
- Priority per cycle: ERR > mem_stall > load_use > flush > normal.
- ERR: pc_write_o=0, ifid_write_o=0, pipe_freeze_o=1, idex_bubble_o=1, flush=0, err_o=1; leaves only on reset.
- mem_stall (RUN or WAIT): pc_write_o=0, ifid_write_o=0, pipe_freeze_o=1, bubble=0, flush=0 (the ID instruction is held, not killed).
- load_use, no mem_stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, pipe_freeze_o=0; flush suppressed (branch operands not yet valid); exactly 1 bubble per load-use pair.
- flush = branch_taken_i | jump_i, no stall: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
- Normal: pc_write_o=1, ifid_write_o=1, all others 0.
- Transitions: RUN->WAIT when mem_stall (wait counter<=1). WAIT: mem_stall -> counter+1; dmem_ready_i -> RUN, counter<=0; mem_stall with counter==TIMEOUT-1 -> ERR. A wait of exactly TIMEOUT cycles with ready on cycle TIMEOUT+1 errors; ready arriving on the TIMEOUT-th wait cycle does not.
- dmem_req_i dropping in WAIT without ready: return to RUN, counter cleared.
- Counters increment when not in reset and the respective condition holds; saturate at 2^CNT_W-1; ERR cycles count as stalls.
- Reset mid-WAIT or in ERR returns to RUN the next cycle; counters cleared.

Decomposition:
- Shared package: state encoding (RUN=2'd0, WAIT=2'd1, ERR=2'd2), REG_ZERO=5'd0, control-vector width 8 and bubble value 8'b0 used by the ID/EX mux.
- Sub-module sat_counter (WIDTH param, inc, clear, value), instantiated twice for stall_cnt_o and flush_cnt_o.

Test Plan:
- lw $2 in EX (idex_rt_i=2, memread=1), add in ID with rs=2, use_rs=1 -> 1 cycle pc_write_o=0, idex_bubble_o=1; next cycle normal; stall_cnt_o=1.
- Same, but idex_rt_i=0 or use_rs_i=use_rt_i=0 (jump) -> no stall, stall_cnt_o=0.
- branch_taken_i=1, no hazard -> ifid_flush_o=1, pc_write_o=1 for 1 cycle, flush_cnt_o=1; with simultaneous load_use -> bubble only, flush_cnt_o=0.
- dmem_req_i=1, ready low 3 cycles then high -> pipe_freeze_o=1 for 3 cycles, state WAIT->RUN, err_o=0, stall_cnt_o=3.
- TIMEOUT=4, ready never asserted -> err_o=1 from cycle 5, outputs frozen; rst_i pulse -> RUN, err_o=0, counters 0.
- CNT_W=3, 10 load-use stalls -> stall_cnt_o holds at 7.
